// File: rtl/clk_div_gen.sv
// clk_div_gen: run-time programmable clock divider producing a duty-controlled
// clk_out, a per-period tick strobe and glitch-free reconfiguration at wraps.
module clk_div_gen #(
  parameter int CNT_W    = 16,
  parameter int DEF_DIV  = 250,
  parameter int DEF_HIGH = 125
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] div_in,
  input  logic [CNT_W-1:0] high_in,
  output logic             clk_out,
  output logic             tick,
  output logic             cfg_ack,
  output logic [CNT_W-1:0] cnt_out
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_DIV  = CNT_W'(2);
  localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEF_HIGH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] shd_div_q, shd_div_d;
  logic [CNT_W-1:0] shd_high_q, shd_high_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;

  logic [CNT_W-1:0] eff_div, eff_high;
  logic             wrap, boundary;

  // Clamp requests so every period has at least two cycles and one low cycle.
  always_comb begin
    eff_div  = (div_in < MIN_DIV) ? MIN_DIV : div_in;
    eff_high = (high_in > (eff_div - ONE)) ? (eff_div - ONE) : high_in;
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no branch can leave one unassigned and infer a latch.
    cnt_d      = cnt_q;
    div_d      = div_q;
    high_d     = high_q;
    shd_div_d  = shd_div_q;
    shd_high_d = shd_high_q;
    pend_d     = pend_q;
    ack_d      = 1'b0;

    wrap     = en && !sync && (cnt_q == (div_q - ONE));
    boundary = sync || wrap;
    tick_d   = wrap;

    if (load) begin
      shd_div_d  = eff_div;
      shd_high_d = eff_high;
      pend_d     = 1'b1;
    end

    if (sync || wrap) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + ONE;
    end

    // The shadow next-value already includes a same-cycle load, so it is forwarded.
    if (boundary && (pend_q || load)) begin
      div_d  = shd_div_d;
      high_d = shd_high_d;
      pend_d = 1'b0;
      ack_d  = 1'b1;
    end

    // Evaluated on next count and next config so the registered output always
    // equals (cnt >= div-high) for the values visible alongside it.
    clk_out_d = (cnt_d >= (div_d - high_d));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      div_q      <= RST_DIV;
      high_q     <= RST_HIGH;
      shd_div_q  <= RST_DIV;
      shd_high_q <= RST_HIGH;
      pend_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      high_q     <= high_d;
      shd_div_q  <= shd_div_d;
      shd_high_q <= shd_high_d;
      pend_q     <= pend_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign cfg_ack = ack_q;
  assign cnt_out = cnt_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: scoreboard bench for clk_div_gen; a behavioural period model
// pushes expected outputs each cycle and a separate monitor compares them.
module tb_clk_div_gen;

  localparam int CNT_W    = 16;
  localparam int DEF_DIV  = 250;
  localparam int DEF_HIGH = 125;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b1;
  logic             sync = 1'b0;
  logic             load = 1'b0;
  logic [CNT_W-1:0] div_in = '0;
  logic [CNT_W-1:0] high_in = '0;
  logic             clk_out, tick, cfg_ack;
  logic [CNT_W-1:0] cnt_out;

  clk_div_gen #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV), .DEF_HIGH(DEF_HIGH)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .load(load),
    .div_in(div_in), .high_in(high_in),
    .clk_out(clk_out), .tick(tick), .cfg_ack(cfg_ack), .cnt_out(cnt_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit co;
    bit tk;
    bit ack;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: one period at a time, in plain integers.
  int m_phase = 0, m_div = DEF_DIV, m_high = DEF_HIGH;
  int m_pdiv = DEF_DIV, m_phigh = DEF_HIGH;
  bit m_pend = 0;

  function automatic int san_div(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int san_high(input int h, input int d);
    return (h > d - 1) ? d - 1 : h;
  endfunction

  always @(posedge clk or negedge rst) begin
    exp_t e;
    bit   at_boundary;
    if (!rst) begin
      m_phase = 0;
      m_div   = DEF_DIV;
      m_high  = DEF_HIGH;
      m_pend  = 0;
      exp_q.delete();
    end else begin
      e.tk = 0;
      e.ack = 0;
      at_boundary = 0;
      if (load) begin
        m_pdiv  = san_div(int'(div_in));
        m_phigh = san_high(int'(high_in), m_pdiv);
        m_pend  = 1;
      end
      if (sync) begin
        m_phase = 0;
        at_boundary = 1;
      end else if (en) begin
        if (m_phase == m_div - 1) begin
          m_phase = 0;
          e.tk = 1;
          at_boundary = 1;
        end else begin
          m_phase++;
        end
      end
      if (at_boundary && m_pend) begin
        m_div  = m_pdiv;
        m_high = m_phigh;
        m_pend = 0;
        e.ack  = 1;
      end
      e.cnt = m_phase;
      e.co  = (m_phase >= m_div - m_high);
      exp_q.push_back(e);
    end
  end

  // Monitor: pops one expectation per clock while out of reset.
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rst) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: no expected entry (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("cnt_out", 32'(cnt_out), 32'(e.cnt));
        check("clk_out", 32'(clk_out), 32'(e.co));
        check("tick",    32'(tick),    32'(e.tk));
        check("cfg_ack", 32'(cfg_ack), 32'(e.ack));
      end
    end
  end

  // Tick-to-tick distance as observed on the DUT output.
  int gap = 0, last_gap = 0;
  initial forever begin
    @(posedge clk);
    #2;
    if (!rst) begin
      gap = 0;
    end else begin
      gap++;
      if (tick) begin
        last_gap = gap;
        gap = 0;
      end
    end
  end

  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk);
      #1;
      if (tick) begin
        n = i;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL tick_timeout: no tick within 2000 cycles (t=%0t)", $time);
  endtask

  task automatic check_gap(input string name, input int exp_gap);
    int n;
    wait_tick(n);
    #2;
    check(name, 32'(last_gap), 32'(exp_gap));
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 2000; i++) begin
      if (m_phase == p) return;
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL phase_timeout: phase %0d not reached (t=%0t)", p, $time);
  endtask

  task automatic do_load(input int d, input int h);
    @(negedge clk);
    load    = 1'b1;
    div_in  = CNT_W'(d);
    high_in = CNT_W'(h);
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cnt",     32'(cnt_out), 32'd0);
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_tick",    32'(tick),    32'd0);
    check("rst_cfg_ack", 32'(cfg_ack), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Defaults: first tick 250 cycles after release, then every 250
    check_gap("first_tick_250", 250);
    check_gap("default_period", 250);

    // Reconfigure mid-period: old period completes, then 10-cycle periods
    wait_phase(60);
    do_load(10, 3);
    check_gap("old_period_kept", 250);
    check("ack_at_wrap", 32'(cfg_ack), 32'd1);
    check_gap("div10_period", 10);

    // Sanitising: div 1 -> 2, high 5 -> 1; then high 0 with div 8
    do_load(1, 5);
    check_gap("div10_last", 10);
    check_gap("div2_period", 2);
    do_load(8, 0);
    check_gap("div2_last", 2);
    check_gap("div8_period", 8);

    // Freeze for 17 cycles at cnt=130 with two loads; latest wins
    do_load(250, 125);
    check_gap("div8_last", 8);
    wait_phase(130);
    @(negedge clk);
    en = 1'b0;
    load = 1'b1; div_in = CNT_W'(20); high_in = CNT_W'(10);
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    load = 1'b1; div_in = CNT_W'(30); high_in = CNT_W'(15);
    @(negedge clk);
    load = 1'b0;
    repeat (10) @(negedge clk);
    check("freeze_cnt",     32'(cnt_out), 32'd130);
    check("freeze_clk_out", 32'(clk_out), 32'd1);
    check("freeze_no_tick", 32'(tick),    32'd0);
    en = 1'b1;
    check_gap("stretched_period", 267);
    check("freeze_ack", 32'(cfg_ack), 32'd1);
    check_gap("div30_period", 30);

    // Sync at cnt=200 with a pending 50/25 config
    do_load(250, 125);
    check_gap("div30_last", 30);
    wait_phase(199);
    do_load(50, 25);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    check("sync_cnt",     32'(cnt_out), 32'd0);
    check("sync_clk_out", 32'(clk_out), 32'd0);
    check("sync_no_tick", 32'(tick),    32'd0);
    check("sync_ack",     32'(cfg_ack), 32'd1);
    wait_tick(n);
    check("sync_to_tick", 32'(n), 32'd50);

    // Randomised traffic with small periods
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      en      = ($urandom_range(0, 9) != 0);
      sync    = ($urandom_range(0, 39) == 0);
      load    = ($urandom_range(0, 11) == 0);
      div_in  = CNT_W'($urandom_range(0, 12));
      high_in = CNT_W'($urandom_range(0, 14));
    end
    @(negedge clk);
    en = 1'b1; sync = 1'b0; load = 1'b0;

    // Asynchronous reset mid-high-phase with a pending config
    do_load(250, 125);
    wait_tick(n);
    wait_phase(180);
    do_load(20, 10);
    @(posedge clk);
    #3;
    check("pre_reset_clk_out", 32'(clk_out), 32'd1);
    rst = 1'b0;
    #1;
    check("async_rst_clk_out", 32'(clk_out), 32'd0);
    check("async_rst_cnt",     32'(cnt_out), 32'd0);
    check("async_rst_tick",    32'(tick),    32'd0);
    check("async_rst_ack",     32'(cfg_ack), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check_gap("post_rst_period", 250);
    check_gap("pending_cleared", 250);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
